// File: rtl/ethclk_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : ethclk_supervisor
// Brief    : Resets the recovered-clock PLL, waits for lock, checks the
//            recovered clock frequency and publishes a qualified clk_ok.
// Revision : 1.0
// ============================================================================
module ethclk_supervisor #(
    parameter int RST_CYCLES   = 64,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int WINDOW       = 4096,
    parameter int EXP_EDGES    = 256,
    parameter int TOL          = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        pll_locked,
    input  logic        tick_tgl,
    input  logic        force_rst,
    output logic        pll_rst,
    output logic        clk_ok,
    output logic [7:0]  retry_cnt,
    output logic [15:0] freq_cnt
);

    typedef enum logic [1:0] {
        ST_RST       = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_MEAS      = 2'd2,
        ST_OK        = 2'd3
    } state_t;

    localparam logic [15:0]        C_RST_LAST  = 16'(RST_CYCLES - 1);
    localparam logic [15:0]        C_LOCK_LAST = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0]        C_WIN_LAST  = 16'(WINDOW - 1);
    localparam logic signed [16:0] C_EXP       = 17'(EXP_EDGES);
    localparam logic signed [16:0] C_TOL       = 17'(TOL);

    logic        lock_meta_q, lock_s_q;
    logic        tgl_meta_q, tgl_s_q, tgl_prev_q;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] edge_cnt_q, edge_cnt_d;
    logic [7:0]  retry_cnt_q, retry_cnt_d;
    logic [15:0] freq_cnt_q, freq_cnt_d;
    logic        pll_rst_q, pll_rst_d;
    logic        clk_ok_q, clk_ok_d;

    logic               w_edge;
    logic [15:0]        w_edge_sum;
    logic signed [16:0] w_diff;
    logic               w_in_range;
    logic [7:0]         w_retry_inc;

    always_comb begin
        w_edge      = tgl_s_q ^ tgl_prev_q;
        // The window total includes the current cycle's edge and sticks at all-ones.
        w_edge_sum  = (edge_cnt_q == 16'hFFFF) ? 16'hFFFF : edge_cnt_q + {15'd0, w_edge};
        w_diff      = $signed({1'b0, w_edge_sum}) - C_EXP;
        w_in_range  = (w_diff >= -C_TOL) && (w_diff <= C_TOL);
        w_retry_inc = (retry_cnt_q == 8'hFF) ? 8'hFF : retry_cnt_q + 8'd1;

        state_d     = state_q;
        cnt_d       = cnt_q + 16'd1;
        edge_cnt_d  = w_edge_sum;
        retry_cnt_d = retry_cnt_q;
        freq_cnt_d  = freq_cnt_q;

        if (force_rst) begin
            state_d    = ST_RST;
            cnt_d      = 16'd0;
            edge_cnt_d = 16'd0;
        end else begin
            case (state_q)
                ST_RST: begin
                    if (cnt_q == C_RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = 16'd0;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s_q) begin
                        state_d    = ST_MEAS;
                        cnt_d      = 16'd0;
                        edge_cnt_d = 16'd0;
                    end else if (cnt_q == C_LOCK_LAST) begin
                        state_d     = ST_RST;
                        cnt_d       = 16'd0;
                        retry_cnt_d = w_retry_inc;
                    end
                end
                ST_MEAS, ST_OK: begin
                    // Lock loss wins over a window ending in the same cycle.
                    if (!lock_s_q) begin
                        state_d     = ST_RST;
                        cnt_d       = 16'd0;
                        retry_cnt_d = w_retry_inc;
                    end else if (cnt_q == C_WIN_LAST) begin
                        freq_cnt_d = w_edge_sum;
                        cnt_d      = 16'd0;
                        edge_cnt_d = 16'd0;
                        if (w_in_range) begin
                            state_d = ST_OK;
                        end else begin
                            state_d     = ST_RST;
                            retry_cnt_d = w_retry_inc;
                        end
                    end
                end
                default: begin
                    state_d = ST_RST;
                    cnt_d   = 16'd0;
                end
            endcase
        end

        pll_rst_d = (state_d == ST_RST);
        clk_ok_d  = (state_d == ST_OK);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            tgl_meta_q  <= 1'b0;
            tgl_s_q     <= 1'b0;
            tgl_prev_q  <= 1'b0;
            state_q     <= ST_RST;
            cnt_q       <= 16'd0;
            edge_cnt_q  <= 16'd0;
            retry_cnt_q <= 8'd0;
            freq_cnt_q  <= 16'd0;
            pll_rst_q   <= 1'b1;
            clk_ok_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_locked;
            lock_s_q    <= lock_meta_q;
            tgl_meta_q  <= tick_tgl;
            tgl_s_q     <= tgl_meta_q;
            tgl_prev_q  <= tgl_s_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            edge_cnt_q  <= edge_cnt_d;
            retry_cnt_q <= retry_cnt_d;
            freq_cnt_q  <= freq_cnt_d;
            pll_rst_q   <= pll_rst_d;
            clk_ok_q    <= clk_ok_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign clk_ok    = clk_ok_q;
    assign retry_cnt = retry_cnt_q;
    assign freq_cnt  = freq_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ethclk_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : tb_ethclk_supervisor
// Brief    : Scoreboard bench for ethclk_supervisor output events.
// Revision : 1.0
// ============================================================================
module tb_ethclk_supervisor;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        pll_locked = 1'b0;
    logic        tick_tgl = 1'b0;
    logic        force_rst = 1'b0;
    logic        pll_rst, clk_ok;
    logic [7:0]  retry_cnt;
    logic [15:0] freq_cnt;
    logic        f_pll_rst, f_clk_ok;
    logic [7:0]  f_retry;
    logic [15:0] f_freq;

    int cyc = 0;
    int n_edges = 256;
    int ph = 0;
    int tests = 0;
    int fails = 0;

    typedef struct {
        string name;
        bit    rst;
        bit    ok;
        int    retry;
        int    freq;
        int    at;
    } ev_t;
    ev_t sb[$];

    ethclk_supervisor #(
        .RST_CYCLES(64), .LOCK_TIMEOUT(1000), .WINDOW(4096), .EXP_EDGES(256), .TOL(4)
    ) u_dut (
        .clk(clk), .rstn(rstn), .pll_locked(pll_locked), .tick_tgl(tick_tgl),
        .force_rst(force_rst), .pll_rst(pll_rst), .clk_ok(clk_ok),
        .retry_cnt(retry_cnt), .freq_cnt(freq_cnt)
    );

    // Short timeouts so retry saturation is reachable quickly.
    ethclk_supervisor #(
        .RST_CYCLES(2), .LOCK_TIMEOUT(4), .WINDOW(4096), .EXP_EDGES(256), .TOL(4)
    ) u_fast (
        .clk(clk), .rstn(rstn), .pll_locked(1'b0), .tick_tgl(1'b0),
        .force_rst(1'b0), .pll_rst(f_pll_rst), .clk_ok(f_clk_ok),
        .retry_cnt(f_retry), .freq_cnt(f_freq)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Toggle pattern periodic over 4096 cycles with exactly n_edges flips per period.
    initial begin
        forever begin
            @(negedge clk);
            ph = (ph + 1) % 4096;
            if (((ph + 1) * n_edges) / 4096 != (ph * n_edges) / 4096)
                tick_tgl = ~tick_tgl;
        end
    end

    task automatic check(input string nm, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic expect_ev(input string nm, input bit r, input bit o,
                             input int rc, input int fc, input int at);
        ev_t e;
        e.name = nm; e.rst = r; e.ok = o; e.retry = rc; e.freq = fc; e.at = at;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse_force();
        force_rst = 1'b1;
        @(negedge clk);
        force_rst = 1'b0;
    endtask

    // Monitor: every change of the output tuple is one event to match.
    initial begin
        logic [25:0] prev, cur;
        ev_t e;
        prev = {1'b1, 1'b0, 8'd0, 16'd0};
        forever begin
            @(negedge clk);
            cur = {pll_rst, clk_ok, retry_cnt, freq_cnt};
            if (rstn && cur !== prev) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_event: got rst=%0b ok=%0b retry=%0d freq=%0d cyc=%0d, expected no event",
                             pll_rst, clk_ok, retry_cnt, freq_cnt, cyc);
                end else begin
                    e = sb.pop_front();
                    if (pll_rst !== e.rst || clk_ok !== e.ok || int'(retry_cnt) != e.retry ||
                        int'(freq_cnt) != e.freq || cyc != e.at) begin
                        fails++;
                        $display("FAIL %s: got rst=%0b ok=%0b retry=%0d freq=%0d cyc=%0d, expected rst=%0b ok=%0b retry=%0d freq=%0d cyc=%0d",
                                 e.name, pll_rst, clk_ok, retry_cnt, freq_cnt, cyc,
                                 e.rst, e.ok, e.retry, e.freq, e.at);
                    end
                end
            end
            prev = cur;
        end
    end

    initial begin
        @(posedge rstn);
        wait_cyc(600);
        check("fast_retry_100", int'(f_retry), 100);
        check("fast_pll_rst_hi", int'(f_pll_rst), 1);
        wait_cyc(603);
        check("fast_pll_rst_lo", int'(f_pll_rst), 0);
        wait_cyc(1600);
        check("fast_retry_sat", int'(f_retry), 255);
        wait_cyc(3000);
        check("fast_retry_hold", int'(f_retry), 255);
    end

    initial begin
        int c;
        repeat (3) @(negedge clk);
        check("rst_pll_rst", int'(pll_rst), 1);
        check("rst_clk_ok", int'(clk_ok), 0);
        check("rst_retry", int'(retry_cnt), 0);
        check("rst_freq", int'(freq_cnt), 0);

        // Nominal start
        expect_ev("nom_rst_fall", 0, 0, 0, 0, 64);
        expect_ev("nom_ok", 0, 1, 0, 256, 4299);
        rstn = 1'b1;
        wait_cyc(200);
        pll_locked = 1'b1;
        wait_cyc(4301);

        // 260 edges: upper pass, via forced restart from OK
        c = cyc;
        n_edges = 260;
        expect_ev("f260_force", 1, 0, 0, 256, c + 1);
        expect_ev("f260_rst_fall", 0, 0, 0, 256, c + 65);
        expect_ev("f260_ok", 0, 1, 0, 260, c + 4162);
        pulse_force();
        wait_cyc(c + 4164);

        // 261 fails, then 252 passes
        c = cyc;
        n_edges = 261;
        expect_ev("f261_force", 1, 0, 0, 260, c + 1);
        expect_ev("f261_rst_fall", 0, 0, 0, 260, c + 65);
        expect_ev("f261_fail", 1, 0, 1, 261, c + 4162);
        expect_ev("f261_rst_fall2", 0, 0, 1, 261, c + 4226);
        expect_ev("f252_ok", 0, 1, 1, 252, c + 8323);
        pulse_force();
        wait_cyc(c + 4162);
        n_edges = 252;
        wait_cyc(c + 8325);

        // 251 fails, then nominal passes
        c = cyc;
        n_edges = 251;
        expect_ev("f251_force", 1, 0, 1, 252, c + 1);
        expect_ev("f251_rst_fall", 0, 0, 1, 252, c + 65);
        expect_ev("f251_fail", 1, 0, 2, 251, c + 4162);
        expect_ev("f251_rst_fall2", 0, 0, 2, 251, c + 4226);
        expect_ev("f256_ok", 0, 1, 2, 256, c + 8323);
        pulse_force();
        wait_cyc(c + 4162);
        n_edges = 256;
        wait_cyc(c + 8325);

        // Lock loss mid-window in OK
        c = cyc;
        wait_cyc(c + 2000);
        c = cyc;
        pll_locked = 1'b0;
        expect_ev("lockloss_drop", 1, 0, 3, 256, c + 3);
        expect_ev("lockloss_rst_fall", 0, 0, 3, 256, c + 67);
        expect_ev("lockloss_ok", 0, 1, 3, 256, c + 4164);
        wait_cyc(c + 10);
        pll_locked = 1'b1;
        wait_cyc(c + 4166);

        // Force coinciding with a lock timeout, then a real timeout
        c = cyc;
        wait_cyc(c + 100);
        c = cyc;
        pll_locked = 1'b0;
        expect_ev("to_drop", 1, 0, 4, 256, c + 3);
        expect_ev("to_rst_fall", 0, 0, 4, 256, c + 67);
        expect_ev("to_force_prio", 1, 0, 4, 256, c + 1067);
        expect_ev("to_rst_fall2", 0, 0, 4, 256, c + 1131);
        expect_ev("to_timeout", 1, 0, 5, 256, c + 2131);
        expect_ev("to_rst_fall3", 0, 0, 5, 256, c + 2195);
        wait_cyc(c + 1066);
        pulse_force();
        wait_cyc(c + 2200);
        pll_locked = 1'b1;
        wait_cyc(c + 2300);
        check("sb_drain", sb.size(), 0);

        // Asynchronous reset while measuring
        check("pre_rst_freq", int'(freq_cnt), 256);
        check("pre_rst_retry", int'(retry_cnt), 5);
        #2;
        rstn = 1'b0;
        #1;
        check("async_pll_rst", int'(pll_rst), 1);
        check("async_clk_ok", int'(clk_ok), 0);
        check("async_freq", int'(freq_cnt), 0);
        check("async_retry", int'(retry_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
